// File: rtl/pooling_ctrl.sv
// pooling_ctrl: per-cycle address/control generator for 2x2, stride-2 max pooling.
//
// Fills row buffer 1 then row buffer 2 from a pixel stream. It then sweeps column
// pairs across both buffers, and repeats this for every row pair of the frame.
// All outputs are registered. Each output shows the action taken by the state
// on the previous enabled edge, so no input reaches an output combinationally.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   enable_i     global advance; 0 freezes state, counters and outputs
//   start_i      frame start pulse, honoured only in idle
//   in_valid_i   pixel present on the stream (fill states only)
//   adrs1_o      row-buffer-1 address
//   adrs2_o      row-buffer-2 address
//   adrs_out_o   pooled-result address
//   mux_en_o     comparator column select (0 even, 1 odd)
//   wr_ctrl1_o   row-buffer-1 write strobe
//   wr_ctrl2_o   row-buffer-2 write strobe
//   out_valid_o  pooled result complete at adrs_out_o
//   pool_done_o  one-cycle frame-complete pulse
//   busy_o       high whenever not idle
//   start_err_o  sticky start-while-busy flag (only with POOL_CTRL_START_ERR_EN)
//
// Build option: define POOL_CTRL_START_ERR_EN to add start_err_o.
module pooling_ctrl #(
    parameter int unsigned ADDRESS_NUM = 4,
    parameter int unsigned FMAP_W      = 8,
    parameter int unsigned FMAP_H      = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   start_i,
    input  logic                   in_valid_i,
    output logic [ADDRESS_NUM-1:0] adrs1_o,
    output logic [ADDRESS_NUM-1:0] adrs2_o,
    output logic [ADDRESS_NUM-1:0] adrs_out_o,
    output logic                   mux_en_o,
    output logic                   wr_ctrl1_o,
    output logic                   wr_ctrl2_o,
    output logic                   out_valid_o,
    output logic                   pool_done_o,
    output logic                   busy_o
`ifdef POOL_CTRL_START_ERR_EN
    ,
    output logic                   start_err_o
`endif
);

    localparam logic [ADDRESS_NUM-1:0] ColLast  = ADDRESS_NUM'(FMAP_W - 1);
    localparam logic [ADDRESS_NUM-1:0] KLast    = ADDRESS_NUM'(FMAP_W / 2 - 1);
    localparam logic [ADDRESS_NUM-1:0] PairLast = ADDRESS_NUM'(FMAP_H / 2 - 1);
    localparam logic [ADDRESS_NUM-1:0] HalfW    = ADDRESS_NUM'(FMAP_W / 2);
    localparam logic [ADDRESS_NUM-1:0] AdrsOne  = ADDRESS_NUM'(1);

    typedef enum logic [2:0] {
        StIdle,
        StFill1,
        StFill2,
        StPool,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDRESS_NUM-1:0] col_q, col_d;
    logic [ADDRESS_NUM-1:0] k_q, k_d;
    logic                   ph_q, ph_d;
    logic [ADDRESS_NUM-1:0] pair_q, pair_d;

    logic [ADDRESS_NUM-1:0] adrs1_q, adrs1_d;
    logic [ADDRESS_NUM-1:0] adrs2_q, adrs2_d;
    logic [ADDRESS_NUM-1:0] adrs_out_q, adrs_out_d;
    logic                   mux_en_q, mux_en_d;
    logic                   wr1_q, wr1_d;
    logic                   wr2_q, wr2_d;
    logic                   out_valid_q, out_valid_d;
    logic                   pool_done_q, pool_done_d;

    // Column address within the pair sweep: 2*k + ph.
    logic [ADDRESS_NUM-1:0] pool_adrs;
    assign pool_adrs = (k_q << 1) | ADDRESS_NUM'(ph_q);

    always_comb begin
        // Everything holds unless an enabled edge says otherwise.
        state_d     = state_q;
        col_d       = col_q;
        k_d         = k_q;
        ph_d        = ph_q;
        pair_d      = pair_q;
        adrs1_d     = adrs1_q;
        adrs2_d     = adrs2_q;
        adrs_out_d  = adrs_out_q;
        mux_en_d    = mux_en_q;
        wr1_d       = wr1_q;
        wr2_d       = wr2_q;
        out_valid_d = out_valid_q;
        pool_done_d = pool_done_q;

        if (enable_i) begin
            wr1_d       = 1'b0;
            wr2_d       = 1'b0;
            out_valid_d = 1'b0;
            mux_en_d    = 1'b0;
            pool_done_d = 1'b0;

            unique case (state_q)
                StIdle: begin
                    adrs1_d    = '0;
                    adrs2_d    = '0;
                    adrs_out_d = '0;
                    if (start_i) begin
                        state_d = StFill1;
                    end
                end
                StFill1: begin
                    // Address tracks the column even on a gap so it visibly holds.
                    adrs1_d = col_q;
                    wr1_d   = in_valid_i;
                    if (in_valid_i) begin
                        if (col_q == ColLast) begin
                            col_d   = '0;
                            state_d = StFill2;
                        end else begin
                            col_d = col_q + AdrsOne;
                        end
                    end
                end
                StFill2: begin
                    adrs2_d = col_q;
                    wr2_d   = in_valid_i;
                    if (in_valid_i) begin
                        if (col_q == ColLast) begin
                            col_d   = '0;
                            state_d = StPool;
                        end else begin
                            col_d = col_q + AdrsOne;
                        end
                    end
                end
                StPool: begin
                    adrs1_d     = pool_adrs;
                    adrs2_d     = pool_adrs;
                    mux_en_d    = ph_q;
                    out_valid_d = ph_q;
                    adrs_out_d  = pair_q * HalfW + k_q;
                    ph_d        = ~ph_q;
                    if (ph_q) begin
                        if (k_q == KLast) begin
                            k_d = '0;
                            if (pair_q == PairLast) begin
                                state_d = StDone;
                            end else begin
                                pair_d  = pair_q + AdrsOne;
                                state_d = StFill1;
                            end
                        end else begin
                            k_d = k_q + AdrsOne;
                        end
                    end
                end
                StDone: begin
                    pool_done_d = 1'b1;
                    adrs1_d     = '0;
                    adrs2_d     = '0;
                    adrs_out_d  = '0;
                    col_d       = '0;
                    k_d         = '0;
                    ph_d        = 1'b0;
                    pair_d      = '0;
                    state_d     = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            col_q       <= '0;
            k_q         <= '0;
            ph_q        <= 1'b0;
            pair_q      <= '0;
            adrs1_q     <= '0;
            adrs2_q     <= '0;
            adrs_out_q  <= '0;
            mux_en_q    <= 1'b0;
            wr1_q       <= 1'b0;
            wr2_q       <= 1'b0;
            out_valid_q <= 1'b0;
            pool_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            k_q         <= k_d;
            ph_q        <= ph_d;
            pair_q      <= pair_d;
            adrs1_q     <= adrs1_d;
            adrs2_q     <= adrs2_d;
            adrs_out_q  <= adrs_out_d;
            mux_en_q    <= mux_en_d;
            wr1_q       <= wr1_d;
            wr2_q       <= wr2_d;
            out_valid_q <= out_valid_d;
            pool_done_q <= pool_done_d;
        end
    end

`ifdef POOL_CTRL_START_ERR_EN
    logic start_err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            start_err_q <= 1'b0;
        end else if (enable_i && start_i && busy_o) begin
            start_err_q <= 1'b1;
        end
    end

    assign start_err_o = start_err_q;
`endif

    assign adrs1_o     = adrs1_q;
    assign adrs2_o     = adrs2_q;
    assign adrs_out_o  = adrs_out_q;
    assign mux_en_o    = mux_en_q;
    assign wr_ctrl1_o  = wr1_q;
    assign wr_ctrl2_o  = wr2_q;
    assign out_valid_o = out_valid_q;
    assign pool_done_o = pool_done_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_pooling_ctrl.sv
module tb_pooling_ctrl;

    localparam int unsigned AW = 4;
    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;

    logic          clk = 1'b0;
    logic          rst, enable, start, in_valid;
    logic [AW-1:0] adrs1, adrs2, adrs_out;
    logic          mux_en, wr1, wr2, out_valid, pool_done, busy;
`ifdef POOL_CTRL_START_ERR_EN
    logic          start_err;
`endif

    pooling_ctrl #(
        .ADDRESS_NUM(AW),
        .FMAP_W     (W),
        .FMAP_H     (H)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .start_i    (start),
        .in_valid_i (in_valid),
        .adrs1_o    (adrs1),
        .adrs2_o    (adrs2),
        .adrs_out_o (adrs_out),
        .mux_en_o   (mux_en),
        .wr_ctrl1_o (wr1),
        .wr_ctrl2_o (wr2),
        .out_valid_o(out_valid),
        .pool_done_o(pool_done),
        .busy_o     (busy)
`ifdef POOL_CTRL_START_ERR_EN
        ,
        .start_err_o(start_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, en, st, iv;
        logic          chk_a1, chk_a2, chk_ao;
        logic [AW-1:0] a1, a2, ao;
        logic          mux, w1, w2, ov, pd, busy;
    } vec_t;

    vec_t vecs[64];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t idle_vec(input logic r, input logic e, input logic s);
        vec_t v;
        v = '{default: 1'b0, a1: '0, a2: '0, ao: '0};
        v.rst = r;  v.en = e;  v.st = s;
        v.chk_a1 = 1'b1;  v.chk_a2 = 1'b1;  v.chk_ao = 1'b1;
        return v;
    endfunction

    // Expected outputs i edges after the start edge of a gap-free frame.
    function automatic vec_t frame_vec(input int i);
        vec_t v;
        int   p, c, j;
        v = idle_vec(1'b0, 1'b1, i == 0);
        v.iv   = 1'b1;
        v.busy = (i <= 48);
        if (i >= 1 && i <= 48) begin
            v.chk_a1 = 1'b0;  v.chk_a2 = 1'b0;  v.chk_ao = 1'b0;
            p = (i - 1) / 24;
            c = (i - 1) % 24;
            if (c < 8) begin
                v.w1 = 1'b1;  v.chk_a1 = 1'b1;  v.a1 = AW'(c);
            end else if (c < 16) begin
                v.w2 = 1'b1;  v.chk_a2 = 1'b1;  v.a2 = AW'(c - 8);
            end else begin
                j = c - 16;
                v.chk_a1 = 1'b1;  v.chk_a2 = 1'b1;  v.chk_ao = 1'b1;
                v.a1 = AW'(j);  v.a2 = AW'(j);
                v.mux = j[0];  v.ov = j[0];
                v.ao = AW'(p * 4 + j / 2);
            end
        end
        v.pd = (i == 49);
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        rst = v.rst;  enable = v.en;  start = v.st;  in_valid = v.iv;
        @(posedge clk);
        #1;
        chk({tag, ".wr1"},  wr1,       v.w1);
        chk({tag, ".wr2"},  wr2,       v.w2);
        chk({tag, ".ov"},   out_valid, v.ov);
        chk({tag, ".mux"},  mux_en,    v.mux);
        chk({tag, ".done"}, pool_done, v.pd);
        chk({tag, ".busy"}, busy,      v.busy);
        if (v.chk_a1) chk({tag, ".adrs1"},    adrs1,    v.a1);
        if (v.chk_a2) chk({tag, ".adrs2"},    adrs2,    v.a2);
        if (v.chk_ao) chk({tag, ".adrs_out"}, adrs_out, v.ao);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to_done(input int budget, output int edges);
        edges = -1;
        for (int i = 1; i <= budget; i++) begin
            step();
            if (pool_done === 1'b1) begin
                edges = i;
                return;
            end
        end
    endtask

    task automatic start_frame();
        enable = 1'b1;  in_valid = 1'b1;  start = 1'b1;
        step();
        start = 1'b0;
    endtask

    int e;
    int seen_done;

    initial begin
        rst = 1'b1;  enable = 1'b0;  start = 1'b0;  in_valid = 1'b0;

        // Reset, idle, gated start, then one full gap-free frame.
        vecs[0] = idle_vec(1'b1, 1'b1, 1'b0);
        vecs[1] = idle_vec(1'b1, 1'b0, 1'b1);
        for (int i = 2; i < 12; i++) vecs[i] = idle_vec(1'b0, 1'b1, 1'b0);
        vecs[12] = idle_vec(1'b0, 1'b0, 1'b1);
        for (int i = 0; i <= 50; i++) vecs[13 + i] = frame_vec(i);

        for (int i = 0; i < 64; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Stream gap of 3 cycles at column 5 of the first fill.
        start_frame();
        repeat (5) step();
        in_valid = 1'b0;
        for (int g = 0; g < 3; g++) begin
            step();
            chk($sformatf("gap%0d.wr1", g), wr1, 1'b0);
            chk($sformatf("gap%0d.adrs1", g), adrs1, 5);
        end
        in_valid = 1'b1;
        step();
        chk("gap_resume.wr1", wr1, 1'b1);
        chk("gap_resume.adrs1", adrs1, 5);
        run_to_done(100, e);
        chk("gap.done_latency", (e < 0) ? 32'hffff_ffff : 32'(9 + e), 52);
        step();
        chk("gap.done_single", pool_done, 1'b0);

        // Stall of 4 cycles in the pool sweep at k=2, ph=1.
        start_frame();
        repeat (21) step();
        chk("stall_pre.adrs_out", adrs_out, 2);
        chk("stall_pre.ov", out_valid, 1'b0);
        enable = 1'b0;  in_valid = 1'b0;  start = 1'b1;
        for (int s = 0; s < 4; s++) begin
            step();
            chk($sformatf("stall%0d.adrs1", s), adrs1, 4);
            chk($sformatf("stall%0d.mux", s), mux_en, 1'b0);
            chk($sformatf("stall%0d.ov", s), out_valid, 1'b0);
            chk($sformatf("stall%0d.adrs_out", s), adrs_out, 2);
            chk($sformatf("stall%0d.busy", s), busy, 1'b1);
        end
        enable = 1'b1;  in_valid = 1'b1;  start = 1'b0;
        step();
        chk("stall_resume.ov", out_valid, 1'b1);
        chk("stall_resume.mux", mux_en, 1'b1);
        chk("stall_resume.adrs1", adrs1, 5);
        chk("stall_resume.adrs_out", adrs_out, 2);
        run_to_done(100, e);
        chk("stall.done_latency", (e < 0) ? 32'hffff_ffff : 32'(26 + e), 53);
`ifdef POOL_CTRL_START_ERR_EN
        chk("stall.start_err", start_err, 1'b0);
`endif

        // Start pulse while busy in the pool sweep.
        start_frame();
        repeat (19) step();
        start = 1'b1;
        step();
        start = 1'b0;
        run_to_done(100, e);
        chk("busy_start.done_latency", (e < 0) ? 32'hffff_ffff : 32'(20 + e), 49);
`ifdef POOL_CTRL_START_ERR_EN
        chk("busy_start.start_err", start_err, 1'b1);
`endif
        repeat (5) step();
        chk("busy_start.idle_after", busy, 1'b0);

        // Abort in the second fill of row pair 1.
        start_frame();
        repeat (35) step();
        chk("abort_pre.wr2", wr2, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.busy", busy, 1'b0);
        chk("abort.wr2", wr2, 1'b0);
        chk("abort.adrs1", adrs1, 0);
        chk("abort.adrs2", adrs2, 0);
        chk("abort.adrs_out", adrs_out, 0);
`ifdef POOL_CTRL_START_ERR_EN
        chk("abort.start_err", start_err, 1'b0);
`endif
        seen_done = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (pool_done === 1'b1 || busy === 1'b1) seen_done++;
        end
        chk("abort.no_done", seen_done, 0);
        for (int i = 0; i <= 50; i++) apply(frame_vec(i), $sformatf("clean%0d", i));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
